alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one instance of the team's 32-bit `alu` between `NREQ` independent requesters, such as a fetch-side address adder and an execute-side unit. Each requester has a valid/ready request channel and a valid/ready response channel. The block grants at most one request per cycle using round-robin priority, drives the shared ALU combinationally, and captures the result in a per-requester response register. It sits between the requesters and the ALU; no other logic touches the ALU's `a`, `b` or `f` inputs.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, legal range 2..8.
- `W`, default 32: operand width. Fixed at 32 because the ALU is 32-bit; any other value is an elaboration error.

Ports:
- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, [NREQ-1:0]: requester i presents an operation.
- `req_ready`, output, [NREQ-1:0]: the operation of requester i is accepted this cycle.
- `req_a`, input, [NREQ-1:0][W-1:0]: operand a of requester i.
- `req_b`, input, [NREQ-1:0][W-1:0]: operand b of requester i.
- `req_f`, input, [NREQ-1:0][2:0]: ALU function code of requester i.
- `rsp_valid`, output, [NREQ-1:0]: a result is held for requester i.
- `rsp_ready`, input, [NREQ-1:0]: requester i consumes its result.
- `rsp_y`, output, [NREQ-1:0][W-1:0]: result for requester i.
- `rsp_zero`, output, [NREQ-1:0]: result for requester i equals 0.
- `rsp_err`, output, [NREQ-1:0]: the operation for requester i used an illegal function code (3'b011).

## Operation
- **Eligibility.** Requester i is eligible when `req_valid[i]` is high and its slot can accept a result. A slot can accept when it is empty (`!rsp_valid[i]`) or is being drained this cycle (`rsp_ready[i]`).
- **Arbitration.**
  - Round-robin priority pointer `ptr` in the range 0..NREQ-1.
  - The first eligible requester at or after `ptr`, wrapping modulo NREQ, is granted.
  - On a grant to index g, `ptr` becomes (g+1) mod NREQ. With no grant, `ptr` holds.
  - `req_ready` is one-hot or zero and equals the grant vector. It is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`.
- **Execution.** The granted requester's a, b and f drive the ALU in the same cycle. With no grant the ALU inputs are driven to 0, so they never carry x.
- **Capture.** On a grant to g, slot g loads `rsp_y` = ALU y and `rsp_zero` = ALU zero on the next edge, and `rsp_valid[g]` is set.
- **Illegal code.** For f = 3'b011: `rsp_y` = 0, `rsp_zero` = 1, `rsp_err` = 1. The ALU's x output is never captured. For all legal codes `rsp_err` = 0.
- **Drain.** `rsp_valid[i] & rsp_ready[i]` with no new grant to i clears `rsp_valid[i]`. `rsp_y`, `rsp_zero` and `rsp_err` hold their last values.
- **Stability.** Requesters keep a, b and f stable while `req_valid` is high and `req_ready` is low. The block does not check this.

## Timing
- **Reset state.** Asserting `reset` at any time immediately clears all `rsp_valid`, `rsp_y`, `rsp_zero` and `rsp_err` to 0 and sets `ptr` to 0.
  - `req_ready` is 0 while reset is held.
  - Any in-flight result is discarded.
- **Latency.** A request accepted at edge N is reflected in `rsp_valid` and the result after edge N. Latency is 1 cycle.
- **Throughput.**
  - One accepted operation per cycle in aggregate.
  - A single requester sustains 1 operation per cycle only if it asserts `rsp_ready` every cycle.
  - Otherwise it waits, because each slot holds one result.
- **Simultaneous drain and grant to the same slot.** The new result overwrites the slot and `rsp_valid` stays 1.
- **Fairness.** With all requesters continuously eligible, each is granted exactly once every NREQ cycles.

## Structure
- **Package `alu_pkg`.**
  - `alu_op_t` enum for the function codes: AND 000, OR 001, ADD 010, ANDN 100, ORN 101, SUB 110, SLT 111.
  - `ALU_W` = 32.
  - An `is_legal_op()` function.
- **Sub-module `rr_arbiter`.** Parameterised by N. Ports: `clk`, `reset`, `req`, `grant`, with the pointer internal. It is reusable elsewhere.
- **Top level.** Instantiates `rr_arbiter`, the existing `alu`, the operand mux and NREQ response slots.

## Test plan
- **Reset.** Assert `reset` mid-traffic -> all `rsp_valid` = 0, `ptr` = 0, `req_ready` = 0 while held. The first grant after release goes to requester 0 when all are valid.
- **Single add.** Requester 0: a=5, b=7, f=010 -> `req_ready[0]` = 1 in the same cycle. Next cycle `rsp_y[0]` = 12, `rsp_zero[0]` = 0, `rsp_valid[0]` = 1.
- **Contention.** Both requesters valid continuously, both `rsp_ready` = 1.
  - Requester 0: SUB 9-9. Requester 1: SLT 3<4.
  - Grants alternate 0, 1, 0, 1.
  - `rsp_y[0]` = 0 with `rsp_zero[0]` = 1; `rsp_y[1]` = 1.
- **Backpressure.**
  - Hold `rsp_ready[1]` = 0 after one result -> `req_ready[1]` stays 0 and requester 0 gets every grant.
  - Raise `rsp_ready[1]` -> requester 1 is granted in that same cycle.
- **Illegal code.** f=011, a=32'hFFFF_FFFF -> `rsp_y` = 0, `rsp_zero` = 1, `rsp_err` = 1, with no x on any output.
- **Wrap.** a=32'hFFFF_FFFF, b=1, f=010 -> `rsp_y` = 0, `rsp_zero` = 1. Also run with NREQ=3 and check the pointer wraps 2 -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit ALU and its requester front end.
// Function codes, datapath width and the legal-code check.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [2:0] {
    OpAnd  = 3'b000,
    OpOr   = 3'b001,
    OpAdd  = 3'b010,
    OpAndn = 3'b100,
    OpOrn  = 3'b101,
    OpSub  = 3'b110,
    OpSlt  = 3'b111
  } alu_op_t;

  // 3'b011 is the only unassigned code.
  function automatic logic is_legal_op(input logic [2:0] f);
    return f != 3'b011;
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU. Bit 2 of f inverts b and adds a carry-in; bits 1:0 select the result.
// The unassigned code produces 0 so nothing downstream ever sees x.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       f,
  output logic [ALU_W-1:0] y,
  output logic             zero
);

  logic [ALU_W-1:0] bb;
  logic [ALU_W-1:0] sum;

  assign bb  = f[2] ? ~b : b;
  assign sum = a + bb + {{(ALU_W-1){1'b0}}, f[2]};

  always_comb begin
    y = '0;
    case (f)
      OpAnd, OpAndn: y = a & bb;
      OpOr, OpOrn:   y = a | bb;
      OpAdd, OpSub:  y = sum;
      OpSlt:         y = {{(ALU_W-1){1'b0}}, sum[ALU_W-1]};
      default:       y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after an internal pointer,
// then moves the pointer one past the winner.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx[PW-1:0];
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters: round-robin grant, combinational execute,
// and a one-entry response slot per requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][W-1:0]   req_a,
  input  logic [NREQ-1:0][W-1:0]   req_b,
  input  logic [NREQ-1:0][2:0]     req_f,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [NREQ-1:0][W-1:0]   rsp_y,
  output logic [NREQ-1:0]          rsp_zero,
  output logic [NREQ-1:0]          rsp_err
);

  if (W != ALU_W) begin : g_bad_width
    $error("alu_arbiter: W must equal ALU_W (32)");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("alu_arbiter: NREQ must be in 2..8");
  end

  logic [NREQ-1:0]        eligible;
  logic [NREQ-1:0]        grant;
  logic [W-1:0]           alu_a, alu_b, alu_y;
  logic [2:0]             alu_f;
  logic                   alu_zero;
  logic                   legal;
  logic [W-1:0]           cap_y;
  logic                   cap_zero;

  logic [NREQ-1:0]        rsp_valid_q;
  logic [NREQ-1:0][W-1:0] rsp_y_q;
  logic [NREQ-1:0]        rsp_zero_q;
  logic [NREQ-1:0]        rsp_err_q;

  // A full slot may still accept if it is being drained this cycle.
  assign eligible = req_valid & (~rsp_valid_q | rsp_ready);

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (eligible),
    .grant(grant)
  );

  assign req_ready = grant & {NREQ{~reset}};

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_f = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        alu_a = req_a[i];
        alu_b = req_b[i];
        alu_f = req_f[i];
      end
    end
  end

  alu u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .f   (alu_f),
    .y   (alu_y),
    .zero(alu_zero)
  );

  assign legal    = is_legal_op(alu_f);
  assign cap_y    = legal ? alu_y : '0;
  assign cap_zero = legal ? alu_zero : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      rsp_zero_q  <= '0;
      rsp_err_q   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_y_q[i]     <= cap_y;
          rsp_zero_q[i]  <= cap_zero;
          rsp_err_q[i]   <= ~legal;
        end else if (rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter: a two-requester instance for the main
// scenarios and a three-requester instance for pointer wrap.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [1:0][31:0] req_a, req_b, rsp_y;
  logic [1:0][2:0]  req_f;

  logic             reset3;
  logic [2:0]       req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_zero3, rsp_err3;
  logic [2:0][31:0] req_a3, req_b3, rsp_y3;
  logic [2:0][2:0]  req_f3;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.NREQ(2), .W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_f    (req_f),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_y    (rsp_y),
    .rsp_zero (rsp_zero),
    .rsp_err  (rsp_err)
  );

  alu_arbiter #(.NREQ(3), .W(32)) dut3 (
    .clk      (clk),
    .reset    (reset3),
    .req_valid(req_valid3),
    .req_ready(req_ready3),
    .req_a    (req_a3),
    .req_b    (req_b3),
    .req_f    (req_f3),
    .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3),
    .rsp_y    (rsp_y3),
    .rsp_zero (rsp_zero3),
    .rsp_err  (rsp_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g2 [4];
  logic [2:0] exp_g3 [4];

  initial begin
    exp_g2 = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_g3 = '{3'b001, 3'b010, 3'b100, 3'b001};

    reset      = 1'b1;
    req_valid  = 2'b11;
    rsp_ready  = 2'b00;
    req_a[0]   = 32'd5;  req_b[0] = 32'd7; req_f[0] = OpAdd;
    req_a[1]   = 32'd3;  req_b[1] = 32'd4; req_f[1] = OpSlt;
    reset3     = 1'b1;
    req_valid3 = 3'b000;
    rsp_ready3 = 3'b111;
    req_a3     = '0;
    req_b3     = '0;
    req_f3     = '0;

    // Reset state
    step();
    step();
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_y0", rsp_y[0], 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);

    // Release with both valid: requester 0 first, then single add result
    reset = 1'b0;
    #1;
    check("first_grant", 32'(req_ready), 32'b01);
    step();
    check("add_y0", rsp_y[0], 32'd12);
    check("add_zero0", 32'(rsp_zero[0]), 32'd0);
    check("add_valid", 32'(rsp_valid), 32'b01);
    check("grant_req1", 32'(req_ready), 32'b10);
    step();
    check("slt_y1", rsp_y[1], 32'd1);
    check("both_full_valid", 32'(rsp_valid), 32'b11);
    check("both_full_ready", 32'(req_ready), 32'b00);

    // Contention with both draining every cycle
    req_a[0]  = 32'd9; req_b[0] = 32'd9; req_f[0] = OpSub;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("contend_grant%0d", i), 32'(req_ready), 32'(exp_g2[i]));
      step();
    end
    check("sub_y0", rsp_y[0], 32'd0);
    check("sub_zero0", 32'(rsp_zero[0]), 32'd1);
    check("contend_y1", rsp_y[1], 32'd1);

    // Backpressure on requester 1
    rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_grant%0d", i), 32'(req_ready), 32'b01);
      check($sformatf("bp_valid1_%0d", i), 32'(rsp_valid[1]), 32'd1);
      step();
    end
    rsp_ready = 2'b11;
    #1;
    check("bp_release_grant", 32'(req_ready), 32'b10);
    step();

    // Illegal function code
    req_valid = 2'b01;
    req_a[0]  = 32'hFFFF_FFFF; req_b[0] = 32'd0; req_f[0] = 3'b011;
    #1;
    check("illegal_grant", 32'(req_ready), 32'b01);
    step();
    check("illegal_y0", rsp_y[0], 32'd0);
    check("illegal_zero0", 32'(rsp_zero[0]), 32'd1);
    check("illegal_err", 32'(rsp_err), 32'b01);
    check("illegal_noX", 32'($isunknown({rsp_y, rsp_zero, rsp_err, rsp_valid})), 32'd0);

    // Wrap-around add
    req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd1; req_f[0] = OpAdd;
    step();
    check("wrap_y0", rsp_y[0], 32'd0);
    check("wrap_zero0", 32'(rsp_zero[0]), 32'd1);
    check("wrap_err0", 32'(rsp_err[0]), 32'd0);

    // Drain with no new grant: valid drops, data holds
    req_valid = 2'b00;
    step();
    check("drain_valid", 32'(rsp_valid), 32'd0);
    check("drain_hold_y1", rsp_y[1], 32'd1);

    // Mid-traffic reset after the pointer has moved to 1
    req_valid = 2'b11;
    req_a[0]  = 32'd5; req_b[0] = 32'd7; req_f[0] = OpAdd;
    step();
    step();
    reset = 1'b1;
    #1;
    check("midreset_valid", 32'(rsp_valid), 32'd0);
    check("midreset_y1", rsp_y[1], 32'd0);
    check("midreset_ready", 32'(req_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("midreset_first_grant", 32'(req_ready), 32'b01);

    // Three requesters: pointer wraps 2 -> 0
    req_valid = 2'b00;
    req_a3[0] = 32'h0000_F0F0; req_b3[0] = 32'h0000_FF00; req_f3[0] = OpAnd;
    req_a3[1] = 32'd0;         req_b3[1] = 32'hFFFF_0000; req_f3[1] = OpOrn;
    req_a3[2] = 32'd10;        req_b3[2] = 32'd3;         req_f3[2] = OpSub;
    req_valid3 = 3'b111;
    step();
    reset3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("n3_grant%0d", i), 32'(req_ready3), 32'(exp_g3[i]));
      step();
    end
    check("n3_and_y0", rsp_y3[0], 32'h0000_F000);
    check("n3_orn_y1", rsp_y3[1], 32'h0000_FFFF);
    check("n3_sub_y2", rsp_y3[2], 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
